// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin owner arbitration for a shared 8-segment display.
// A 1 ms prescaler drives the minimum-hold timer and the inter-owner gap.
module disp_arbiter #(
    parameter int unsigned CLK_IN_MHZ   = 125,
    parameter logic        LED_POLARITY = 1'b1,
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned HOLD_MS      = 500
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*8-1:0]       pat_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] owner_o,
    output logic [7:0]               seg_display_o,
    output logic                     tick_o
);

    localparam int unsigned OW   = $clog2(N_REQ);
    localparam int unsigned TERM = CLK_IN_MHZ * 1000;
    localparam int unsigned CW   = $clog2(TERM);
    localparam int unsigned HW   = $clog2(HOLD_MS + 1);

    localparam logic [CW-1:0]    CNT_LAST = CW'(TERM - 1);
    localparam logic [HW-1:0]    HOLD_MAX = HW'(HOLD_MS);
    localparam logic [OW-1:0]    LAST_RST = OW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
    localparam logic [7:0]       BLANK    = LED_POLARITY ? 8'h00 : 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [OW-1:0]     last_q, last_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [7:0]        seg_q, seg_d;

    logic              go;
    logic [OW-1:0]     pick;
    logic [OW-1:0]     sel;
    logic              others;
    logic [7:0]        raw;

    // Lowest set request strictly after 'last', wrapping around.
    function automatic logic [OW-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [OW-1:0]    last
    );
        logic [OW-1:0] p;
        logic          found;
        logic [31:0]   idx;
        p     = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = 32'(last) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx[OW-1:0]]) begin
                p     = idx[OW-1:0];
                found = 1'b1;
            end
        end
        return p;
    endfunction

    // Next-state logic: prescaler, arbitration FSM and registered outputs.
    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        tick_d  = (cnt_q == CNT_LAST);
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        go      = 1'b0;
        pick    = rr_pick(req_i, last_q);
        others  = |(req_i & ~grant_q);
        sel     = owner_q;
        unique case (state_q)
            IDLE: begin
                if (|req_i) go = 1'b1;
            end
            GRANT: begin
                if (!req_i[owner_q] || (hold_q == HOLD_MAX && others)) begin
                    state_d = GAP;
                end else if (tick_q && hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                if (tick_q) begin
                    if (|req_i) go = 1'b1;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (go) begin
            state_d = GRANT;
            sel     = pick;
            last_d  = pick;
            hold_d  = '0;
        end
        raw = pat_i[{sel, 3'b000} +: 8];
        if (state_d == GRANT) begin
            grant_d = ONE << sel;
            owner_d = sel;
            seg_d   = LED_POLARITY ? raw : ~raw;
        end else begin
            grant_d = '0;
            owner_d = '0;
            seg_d   = BLANK;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            hold_q  <= '0;
            last_q  <= LAST_RST;
            grant_q <= '0;
            owner_q <= '0;
            seg_q   <= BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            seg_q   <= seg_d;
        end
    end

    assign grant_o       = grant_q;
    assign owner_o       = owner_q;
    assign seg_display_o = seg_q;
    assign tick_o        = tick_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed vectors for disp_arbiter at 1 MHz, 3 ms hold.
// Two instances share stimulus; the second uses active-low segments.
module tb_disp_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] pat1 = {8'h88, 8'h44, 8'h22, 8'h11};
    logic [31:0] pat2 = {4{8'h3C}};

    logic [3:0]  grant1, grant2;
    logic [1:0]  owner1, owner2;
    logic [7:0]  seg1, seg2;
    logic        tick1, tick2;

    int n_assert = 0;
    int n_fail   = 0;
    int mon_bad  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    disp_arbiter #(
        .CLK_IN_MHZ(1), .LED_POLARITY(1'b1), .N_REQ(4), .HOLD_MS(3)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .pat_i(pat1),
        .grant_o(grant1), .owner_o(owner1),
        .seg_display_o(seg1), .tick_o(tick1)
    );

    disp_arbiter #(
        .CLK_IN_MHZ(1), .LED_POLARITY(1'b0), .N_REQ(4), .HOLD_MS(3)
    ) dut_n (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .pat_i(pat2),
        .grant_o(grant2), .owner_o(owner2),
        .seg_display_o(seg2), .tick_o(tick2)
    );

    // Grant must stay one-hot-or-zero, owner zero when nothing granted.
    always @(negedge clk) begin
        if (rstn) begin
            if (!$onehot0(grant1) || (grant1 == 4'b0 && owner1 != 2'd0))
                mon_bad <= mon_bad + 1;
            if (!$onehot0(grant2) || (grant2 == 4'b0 && owner2 != 2'd0))
                mon_bad <= mon_bad + 1;
        end
    end

    typedef struct {
        bit         rst;
        int         cyc;
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] o;
        logic [7:0] seg;
        logic [7:0] segn;
        logic       tick;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit r, int c, logic [3:0] rq, logic [3:0] g,
                                logic [1:0] o, logic [7:0] s, logic [7:0] sn,
                                logic t);
        vec_t v;
        v.rst = r; v.cyc = c; v.req = rq; v.g = g; v.o = o;
        v.seg = s; v.segn = sn; v.tick = t;
        return v;
    endfunction

    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic check(input string name, input bit ok, input string got,
                         input string want);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, want %s", name, got, want);
        end
    endtask

    // Assert reset away from any edge, verify async clear, then release.
    task automatic do_reset(input logic [3:0] r);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("reset_state",
              grant1 == 4'b0 && owner1 == 2'd0 && seg1 == 8'h00 &&
              tick1 == 1'b0 && grant2 == 4'b0 && owner2 == 2'd0 &&
              seg2 == 8'hFF && tick2 == 1'b0,
              $sformatf("g=%b o=%0d s=%h sn=%h t=%b",
                        grant1, owner1, seg1, seg2, tick1),
              "g=0000 o=0 s=00 sn=ff t=0");
        req = r;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cyc  = 0;
    endtask

    initial begin
        int bad;
        // req 0101: owner 0, hold, gap, owner 2, gap, owner 0
        vq.push_back(mk(1,    1, 4'b0101, 4'b0001, 0, 8'h11, 8'hC3, 0));
        vq.push_back(mk(0,  999, 4'b0101, 4'b0001, 0, 8'h11, 8'hC3, 0));
        vq.push_back(mk(0, 1000, 4'b0101, 4'b0001, 0, 8'h11, 8'hC3, 1));
        vq.push_back(mk(0, 1001, 4'b0101, 4'b0001, 0, 8'h11, 8'hC3, 0));
        vq.push_back(mk(0, 2000, 4'b0101, 4'b0001, 0, 8'h11, 8'hC3, 1));
        vq.push_back(mk(0, 3001, 4'b0101, 4'b0001, 0, 8'h11, 8'hC3, 0));
        vq.push_back(mk(0, 3002, 4'b0101, 4'b0000, 0, 8'h00, 8'hFF, 0));
        vq.push_back(mk(0, 4000, 4'b0101, 4'b0000, 0, 8'h00, 8'hFF, 1));
        vq.push_back(mk(0, 4001, 4'b0101, 4'b0100, 2, 8'h44, 8'hC3, 0));
        vq.push_back(mk(0, 5000, 4'b0101, 4'b0100, 2, 8'h44, 8'hC3, 1));
        vq.push_back(mk(0, 7001, 4'b0101, 4'b0100, 2, 8'h44, 8'hC3, 0));
        vq.push_back(mk(0, 7002, 4'b0101, 4'b0000, 0, 8'h00, 8'hFF, 0));
        vq.push_back(mk(0, 8001, 4'b0101, 4'b0001, 0, 8'h11, 8'hC3, 0));
        // reset mid-grant of owner 0; all requesting, 0 must still win
        vq.push_back(mk(1,    1, 4'b1111, 4'b0001, 0, 8'h11, 8'hC3, 0));
        vq.push_back(mk(0,  999, 4'b1111, 4'b0001, 0, 8'h11, 8'hC3, 0));
        vq.push_back(mk(0, 1000, 4'b1111, 4'b0001, 0, 8'h11, 8'hC3, 1));
        vq.push_back(mk(0, 3002, 4'b1111, 4'b0000, 0, 8'h00, 8'hFF, 0));
        vq.push_back(mk(0, 4001, 4'b1111, 4'b0010, 1, 8'h22, 8'hC3, 0));
        // owner 1 drops early, 3 waiting; then idle and re-request
        vq.push_back(mk(1,    1, 4'b1010, 4'b0010, 1, 8'h22, 8'hC3, 0));
        vq.push_back(mk(0, 1500, 4'b1010, 4'b0010, 1, 8'h22, 8'hC3, 0));
        vq.push_back(mk(0, 1501, 4'b1000, 4'b0000, 0, 8'h00, 8'hFF, 0));
        vq.push_back(mk(0, 2000, 4'b1000, 4'b0000, 0, 8'h00, 8'hFF, 1));
        vq.push_back(mk(0, 2001, 4'b1000, 4'b1000, 3, 8'h88, 8'hC3, 0));
        vq.push_back(mk(0, 2002, 4'b0000, 4'b0000, 0, 8'h00, 8'hFF, 0));
        vq.push_back(mk(0, 3001, 4'b0000, 4'b0000, 0, 8'h00, 8'hFF, 0));
        vq.push_back(mk(0, 3002, 4'b0001, 4'b0001, 0, 8'h11, 8'hC3, 0));

        foreach (vq[i]) begin
            if (vq[i].rst) do_reset(vq[i].req);
            else           req = vq[i].req;
            run_to(vq[i].cyc);
            check($sformatf("vec%0d_cyc%0d", i, vq[i].cyc),
                  grant1 == vq[i].g && owner1 == vq[i].o &&
                  seg1 == vq[i].seg && seg2 == vq[i].segn &&
                  tick1 == vq[i].tick && tick2 == vq[i].tick &&
                  grant2 == vq[i].g,
                  $sformatf("g=%b o=%0d s=%h sn=%h t=%b",
                            grant1, owner1, seg1, seg2, tick1),
                  $sformatf("g=%b o=%0d s=%h sn=%h t=%b",
                            vq[i].g, vq[i].o, vq[i].seg, vq[i].segn,
                            vq[i].tick));
        end

        // single requester 2 kept for 10 ms: never leaves grant
        do_reset(4'b0100);
        run_to(1);
        bad = 0;
        for (int k = 0; k < 10000; k++) begin
            run_to(cyc + 1);
            if (grant1 != 4'b0100 || seg1 != 8'h44 || seg2 != 8'hC3)
                bad++;
        end
        check("solo_hold_10ms", bad == 0,
              $sformatf("%0d bad cycles", bad), "0 bad cycles");

        // pattern change shows up after exactly one edge
        pat1[23:16] = 8'h5A;
        #1;
        check("pat_latency_before", seg1 == 8'h44,
              $sformatf("%h", seg1), "44");
        run_to(cyc + 1);
        check("pat_latency_after", seg1 == 8'h5A,
              $sformatf("%h", seg1), "5a");

        check("onehot_monitor", mon_bad == 0,
              $sformatf("%0d violations", mon_bad), "0 violations");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 The block SHALL have parameter CLK_IN_MHZ, default 125: input clock frequency in MHz, integer 1..200.
REQ-002 The block SHALL have parameter LED_POLARITY, default 1'b1: 1 = segment on when driven high, 0 = segment on when driven low.
REQ-003 The block SHALL have parameter N_REQ, default 4: number of requesters, 2..8.
REQ-004 The block SHALL have parameter HOLD_MS, default 500: minimum ownership time in ms ticks, >= 1.
REQ-005 The block SHALL have port clk_i, input, 1 bit: single system clock.
REQ-006 The block SHALL have port rstn_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 The block SHALL have port req_i, input, N_REQ bits: per-requester display request, level.
REQ-008 The block SHALL have port pat_i, input, N_REQ*8 bits: per-requester segment pattern, bit=1 means segment on; requester k uses bits [8k+7:8k].
REQ-009 The block SHALL have port grant_o, output, N_REQ bits: one-hot current owner, all-zero when no owner.
REQ-010 The block SHALL have port owner_o, output, $clog2(N_REQ) bits: index of current owner, valid only while grant_o != 0.
REQ-011 The block SHALL have port seg_display_o, output, 8 bits: polarity-corrected segment drive.
REQ-012 The block SHALL have port tick_o, output, 1 bit: one-cycle pulse every 1 ms.

Function
REQ-013 The block SHALL implement a free-running prescaler that counts 0..CLK_IN_MHZ*1000-1 and pulses tick_o high for exactly one cycle on the terminal count.
REQ-014 The block SHALL implement an FSM with states IDLE, GRANT and GAP.
REQ-015 IDLE SHALL hold grant_o=0 and blank the display; on the first cycle with req_i != 0, the FSM SHALL select an owner by round-robin and move to GRANT, with grant_o asserted on the next clock edge.
REQ-016 Round-robin selection SHALL pick the lowest index above last_owner, wrapping modulo N_REQ, among the set req_i bits; last_owner SHALL update when a grant is issued.
REQ-017 In GRANT, seg_display_o SHALL be registered as pat_i[owner] when LED_POLARITY=1, or ~pat_i[owner] when LED_POLARITY=0, with 1-cycle latency from pat_i.
REQ-018 In GRANT, a hold counter SHALL be cleared on entry and SHALL increment on each tick_o, saturating at HOLD_MS.
REQ-019 In GRANT, if req_i[owner]=0, the FSM SHALL move to GAP on the next edge, regardless of the hold count.
REQ-020 In GRANT, if hold count = HOLD_MS and any other req_i bit is set, the FSM SHALL move to GAP.
REQ-021 In GRANT, if hold count = HOLD_MS and no other requester is set, the FSM SHALL stay in GRANT with no re-arbitration.
REQ-022 GAP SHALL hold grant_o=0 and blank the display until the next tick_o.
REQ-023 On the tick that ends GAP, the FSM SHALL go to GRANT if any req_i bit is set (round-robin per REQ-016); otherwise it SHALL go to IDLE.
REQ-024 Blank SHALL mean seg_display_o = 8'h00 when LED_POLARITY=1, and 8'hFF when LED_POLARITY=0.
REQ-025 If the owner drop (REQ-019) and hold expiry (REQ-020) occur in the same cycle, the FSM SHALL go to GAP once; no double transition is allowed.
REQ-026 A requester that has just released ownership SHALL be eligible again only after all other set requesters have been served.
REQ-027 grant_o SHALL never have more than one bit set; owner_o SHALL be 0 whenever grant_o=0.

Reset
REQ-028 While rstn_i=0, the block SHALL hold: FSM=IDLE, prescaler=0, hold count=0, last_owner=N_REQ-1, grant_o=0, owner_o=0, tick_o=0, seg_display_o=blank.
REQ-029 Reset SHALL assert asynchronously, including mid-GRANT, and SHALL deassert synchronously to clk_i through the external reset synchroniser.
REQ-030 After reset release, the first tick_o SHALL occur CLK_IN_MHZ*1000 cycles later.

Verification (CLK_IN_MHZ=1, HOLD_MS=3, N_REQ=4, LED_POLARITY=1 unless stated)
REQ-031 Test: tick period -> tick_o pulses every 1000 cycles, each pulse 1 cycle wide.
REQ-032 Test: req_i=4'b0101 from reset -> requester 0 granted; at hold expiry, GAP of 1 tick; then requester 2 granted; then requester 0 again.
REQ-033 Test: owner 1 drops req mid-hold with req_i[3]=1 -> GAP on the next edge; requester 3 granted at the next tick.
REQ-034 Test: single requester 2 held for 10 ms -> grant_o=4'b0100 throughout, no GAP.
REQ-035 Test: LED_POLARITY=0, pat=8'h3C -> seg_display_o=8'hC3 in GRANT and 8'hFF in IDLE/GAP.
REQ-036 Test: rstn_i pulsed low mid-GRANT -> outputs reach reset values without a clock edge; after release, requester 0 wins first.
